uart_io_ctl: RTL
================

Name: uart_io_ctl

Overview:
- CPU-side peripheral controller for the UART pair; it is the responder to the CPU's INP/OUT/SKI/SKO/ION/IOF I/O instructions.
- Receive side: captures completed frames from uart_rx into an RX FIFO and presents the head byte as INPR, with FGI meaning "RX FIFO not empty".
- Transmit side: accepts OUTR bytes into a TX FIFO and drains them to uart_tx by generating the falling-edge fgo launch and tracking tx_rdy, with FGO meaning "TX FIFO not full".
- Also produces the interrupt request.

Parameters:
- DEPTH_LOG2, 2, log2 of each FIFO depth (default 4 entries per FIFO).
- DROP_ERR, 1, 1 = frames with rx_error are counted and discarded; 0 = counted and still pushed.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_byte_out  in  8  byte from uart_rx.
- rx_error  in  1  frame/parity error flag from uart_rx.
- rx_rdy  in  1  uart_rx ready level (high after a frame completes).
- tx_byte_in  out  8  byte to uart_tx.
- fgo  out  1  uart_tx launch line (falling edge starts a frame).
- tx_rdy  in  1  uart_tx idle.
- cpu_inp  in  1  one-cycle pop strobe (INP).
- cpu_out  in  1  one-cycle push strobe (OUT).
- outr  in  8  byte to send, sampled with cpu_out.
- cpu_ion  in  1  set interrupt enable.
- cpu_iof  in  1  clear interrupt enable.
- stat_clr  in  1  clear sticky status and the error counter.
- inpr  out  8  RX FIFO head.
- fgi  out  1  RX FIFO not empty.
- fgo_cpu  out  1  TX FIFO not full.
- irq  out  1  interrupt request.
- rx_ovf  out  1  sticky: a received byte was dropped because the RX FIFO was full.
- tx_ovf  out  1  sticky: cpu_out was ignored because the TX FIFO was full.
- err_cnt  out  8  saturating count of rx_error frames.

Behaviour:
- Reset values:
  - Both FIFOs empty; fgi=0; fgo_cpu=1; inpr=8'h00.
  - tx_byte_in=8'h00; fgo=1; tx FSM in IDLE.
  - ien=0; irq=0; rx_ovf=0; tx_ovf=0; err_cnt=0.
  - The internal rx_rdy_prev register resets to 0.
- Reset mid-frame: the FSM aborts to IDLE with fgo=1; the uart_tx frame already in flight is not tracked.
- RX capture:
  - rx_rise = rx_rdy & ~rx_rdy_prev, registered each cycle.
  - On rx_rise with rx_error=1: err_cnt increments, saturating at 8'hFF. If DROP_ERR=1 the byte is discarded.
  - Otherwise on rx_rise the byte is pushed. The byte becomes visible on inpr/fgi the cycle after rx_rise.
  - When the RX FIFO is full the byte is dropped and rx_ovf is set.
  - Simultaneous cpu_inp and push when the RX FIFO is full: the pop and the push both take effect, and no overflow is flagged.
- CPU read:
  - inpr shows the head entry when fgi=1, otherwise 8'h00.
  - cpu_inp while fgi=1 pops the head, effective next cycle.
  - cpu_inp while the FIFO is empty is ignored.
- CPU write:
  - cpu_out while fgo_cpu=1 pushes outr.
  - cpu_out while the FIFO is full is ignored and sets tx_ovf.
  - Simultaneous cpu_out and FSM pop on a full FIFO: the push is accepted.
- TX FSM:
  - IDLE: fgo=1. If the TX FIFO is not empty and tx_rdy=1, pop the head into tx_byte_in and go to LAUNCH.
  - LAUNCH: fgo=0 for exactly one cycle, with tx_byte_in held stable. Then go to WAIT_BUSY with fgo=1.
  - WAIT_BUSY: stay until tx_rdy=0, then go to WAIT_DONE.
  - WAIT_DONE: stay until tx_rdy=1, then go to IDLE.
  - tx_byte_in holds its value until the next pop.
  - Back-to-back bytes: the next LAUNCH begins no earlier than 1 cycle after tx_rdy returns high.
- Interrupt enable: cpu_iof has priority over cpu_ion and clears ien. ien takes its new value next cycle.
- irq = ien & (fgi | (fgo_cpu & tx_fifo_empty)), registered, so it lags the flags by 1 cycle.
- stat_clr clears rx_ovf, tx_ovf and err_cnt. A status-setting event in the same cycle as stat_clr wins.
- FIFO pointers are DEPTH_LOG2+1 bits wide and wrap modulo 2^(DEPTH_LOG2+1).
  - full = MSBs differ and the low bits are equal.
  - empty = pointers equal.

Test Plan:
- RX ordering: rx_rdy pulses high with bytes 8'h41, then 8'h42 (rx_error=0) -> fgi=1 one cycle after the first rise, inpr=41. After cpu_inp inpr=42; after a second cpu_inp fgi=0 and inpr=00.
- RX overflow: 5 error-free frames with no cpu_inp, DEPTH_LOG2=2 -> rx_ovf=1, FIFO holds the first 4 bytes in order, fifth byte lost.
- RX error: one frame with rx_error=1 and DROP_ERR=1 -> err_cnt=1, fgi stays 0. 256 such frames -> err_cnt=FF.
- TX drain with a uart_tx model: cpu_out with 8'h55, then 8'hAA -> two single-cycle fgo lows; tx_byte_in=55 on the first and AA on the second. The second launch follows only after tx_rdy has fallen and returned to 1.
- TX full: 5 cpu_out strobes while tx_rdy is held at 0 -> fgo_cpu=0 after the 4th strobe, tx_ovf=1, no fgo low occurs until tx_rdy=1.
- Interrupt and reset: cpu_ion with the RX FIFO empty and the TX FIFO empty -> irq=1. Then cpu_ion and cpu_iof asserted together -> ien=0, irq=0. Reset asserted during WAIT_BUSY -> fgo=1, FSM IDLE, both FIFOs empty next cycle.

Source files
------------

// File: rtl/uart_io_ctl.sv
// CPU-side I/O responder for the UART pair: RX/TX byte FIFOs, the uart_tx launch
// sequencer, sticky status, a saturating error counter and the interrupt request.
module uart_io_ctl #(
    parameter int DEPTH_LOG2 = 2,
    parameter bit DROP_ERR   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_byte_out,
    input  logic       rx_error,
    input  logic       rx_rdy,
    output logic [7:0] tx_byte_in,
    output logic       fgo,
    input  logic       tx_rdy,
    input  logic       cpu_inp,
    input  logic       cpu_out,
    input  logic [7:0] outr,
    input  logic       cpu_ion,
    input  logic       cpu_iof,
    input  logic       stat_clr,
    output logic [7:0] inpr,
    output logic       fgi,
    output logic       fgo_cpu,
    output logic       irq,
    output logic       rx_ovf,
    output logic       tx_ovf,
    output logic [7:0] err_cnt
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} tx_state_t;

    logic [7:0]    rx_mem [DEPTH];
    logic [7:0]    tx_mem [DEPTH];
    logic [PW-1:0] rx_wr, rx_rd, tx_wr, tx_rd;
    logic          rx_empty, rx_full, tx_empty, tx_full;
    logic          rx_rdy_prev, rx_rise, rx_push_req, rx_push, rx_pop, rx_drop, err_evt;
    logic          tx_push, tx_pop, tx_rej, ien;
    tx_state_t     state, state_next;

    assign rx_empty = (rx_wr == rx_rd);
    assign rx_full  = (rx_wr[PW-1] != rx_rd[PW-1]) && (rx_wr[PW-2:0] == rx_rd[PW-2:0]);
    assign tx_empty = (tx_wr == tx_rd);
    assign tx_full  = (tx_wr[PW-1] != tx_rd[PW-1]) && (tx_wr[PW-2:0] == tx_rd[PW-2:0]);

    // A pop in the same cycle frees the slot, so a full FIFO can still accept the push.
    assign rx_rise     = rx_rdy & ~rx_rdy_prev;
    assign err_evt     = rx_rise & rx_error;
    assign rx_push_req = rx_rise & (~rx_error | ~DROP_ERR);
    assign rx_pop      = cpu_inp & ~rx_empty;
    assign rx_push     = rx_push_req & (~rx_full | rx_pop);
    assign rx_drop     = rx_push_req & rx_full & ~rx_pop;
    assign tx_push     = cpu_out & (~tx_full | tx_pop);
    assign tx_rej      = cpu_out & tx_full & ~tx_pop;

    assign fgi     = ~rx_empty;
    assign fgo_cpu = ~tx_full;
    assign inpr    = rx_empty ? 8'h00 : rx_mem[rx_rd[PW-2:0]];

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr[PW-2:0]] <= rx_byte_out;
        if (tx_push) tx_mem[tx_wr[PW-2:0]] <= outr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wr <= '0;
            rx_rd <= '0;
            tx_wr <= '0;
            tx_rd <= '0;
        end else begin
            if (rx_push) rx_wr <= rx_wr + PW'(1);
            if (rx_pop)  rx_rd <= rx_rd + PW'(1);
            if (tx_push) tx_wr <= tx_wr + PW'(1);
            if (tx_pop)  tx_rd <= tx_rd + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // fgo drops for the single LAUNCH cycle; uart_tx then handshakes via tx_rdy.
    always_comb begin
        state_next = state;
        tx_pop     = 1'b0;
        fgo        = 1'b1;
        case (state)
            IDLE: begin
                if (!tx_empty && tx_rdy) begin
                    tx_pop     = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                fgo        = 1'b0;
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: if (!tx_rdy) state_next = WAIT_DONE;
            WAIT_DONE: if (tx_rdy)  state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)       tx_byte_in <= 8'h00;
        else if (tx_pop) tx_byte_in <= tx_mem[tx_rd[PW-2:0]];
    end

    // Status-setting events take priority over stat_clr.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_rdy_prev <= 1'b0;
            ien         <= 1'b0;
            irq         <= 1'b0;
            rx_ovf      <= 1'b0;
            tx_ovf      <= 1'b0;
            err_cnt     <= 8'h00;
        end else begin
            rx_rdy_prev <= rx_rdy;
            if (cpu_iof)      ien <= 1'b0;
            else if (cpu_ion) ien <= 1'b1;
            irq <= ien & (fgi | (fgo_cpu & tx_empty));
            if (rx_drop)       rx_ovf <= 1'b1;
            else if (stat_clr) rx_ovf <= 1'b0;
            if (tx_rej)        tx_ovf <= 1'b1;
            else if (stat_clr) tx_ovf <= 1'b0;
            if (err_evt) begin
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end else if (stat_clr) begin
                err_cnt <= 8'h00;
            end
        end
    end
endmodule
